// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between a controller and the PS/2 host
// transmitter.
//   i_byte  (ctrl -> tx) command byte, sampled when i_send is accepted
//   i_send  (ctrl -> tx) start request, accepted only while the tx is idle
//   o_busy  (tx -> ctrl) transmission in progress; mouse receiver should ignore the lines
//   o_done  (tx -> ctrl) one-cycle pulse, device acknowledged and lines idle
//   o_error (tx -> ctrl) one-cycle pulse, missing acknowledge or watchdog expiry
// The PS/2 lines themselves are open-drain inouts and stay plain module ports.
interface ps2_host_tx_if;
    logic [7:0] i_byte;
    logic       i_send;
    logic       o_busy;
    logic       o_done;
    logic       o_error;

    modport master (output i_byte, output i_send, input o_busy, input o_done, input o_error);
    modport slave  (input i_byte, input i_send, output o_busy, output o_done, output o_error);
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Runs the request-to-send
// sequence, shifts a command frame out on device clock edges and checks the
// device acknowledge.
// Ports:
//   clk      system clock
//   reset    synchronous, active-high
//   bus      ps2_host_tx_if.slave (i_byte, i_send, o_busy, o_done, o_error)
//   ps2_clk  open-drain PS/2 clock, driven 0 or z only
//   ps2_dat  open-drain PS/2 data, driven 0 or z only
// Build option: define PS2_TX_TIMEOUT_EN to enable a watchdog that runs from
// request-to-send until the end of the transfer.
//
// state       | meaning
// S_IDLE      | lines released, waiting for i_send
// S_INHIBIT   | holding ps2_clk low for INHIBIT_CYCLES
// S_RTS       | start bit driven, waiting for ps2_clk to read back high
// S_DATA      | shifting data, parity and stop on device falling edges
// S_ACK       | sampling device acknowledge on the next falling edge
// S_WAIT_IDLE | waiting for both lines high before signalling done
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic         clk,
    input  logic         reset,
    ps2_host_tx_if.slave bus,
    inout  wire          ps2_clk,
    inout  wire          ps2_dat
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_DATA, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [9:0]       frame_q, frame_d;
    logic [3:0]       edge_cnt_q, edge_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             clk_s1_q, clk_s2_q, clk_s3_q;
    logic             dat_s1_q, dat_s2_q;
    logic             clk_fall;
    logic             tmo_expired;

    assign ps2_clk = clk_oe_q ? 1'b0 : 1'bz;
    assign ps2_dat = dat_oe_q ? 1'b0 : 1'bz;

    assign clk_fall = clk_s3_q & ~clk_s2_q;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Reloaded every inhibit cycle so RTS entry starts with a full budget.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == S_INHIBIT) begin
            tmo_d = TMO_W'(TIMEOUT_CYCLES - 1);
        end else if (tmo_q != '0) begin
            tmo_d = tmo_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end

    assign tmo_expired = (tmo_q == '0);
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        edge_cnt_d = edge_cnt_q;
        inh_cnt_d  = inh_cnt_q;
        dat_oe_d   = dat_oe_q;
        done_d     = 1'b0;
        error_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                dat_oe_d   = 1'b0;
                edge_cnt_d = '0;
                // Holding off during the done/error pulse gives the controller
                // a clean cycle before the next request is taken.
                if (bus.i_send && !done_q && !error_q) begin
                    frame_d   = {1'b1, ~^bus.i_byte, bus.i_byte};
                    inh_cnt_d = INH_W'(INHIBIT_CYCLES - 1);
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_cnt_q == '0) begin
                    dat_oe_d = 1'b1;
                    state_d  = S_RTS;
                end else begin
                    inh_cnt_d = inh_cnt_q - 1'b1;
                end
            end
            S_RTS: begin
                // Our own clock release must be seen before any edge counts.
                if (clk_s2_q) begin
                    edge_cnt_d = '0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (clk_fall) begin
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    dat_oe_d   = ~frame_q[0];
                    frame_d    = {1'b1, frame_q[9:1]};
                    if (edge_cnt_q == 4'd9) state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (clk_fall) begin
                    if (!dat_s2_q) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s2_q && dat_s2_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (tmo_expired && (state_q inside {S_RTS, S_DATA, S_ACK, S_WAIT_IDLE})) begin
            state_d  = S_IDLE;
            dat_oe_d = 1'b0;
            done_d   = 1'b0;
            error_d  = 1'b1;
        end

        clk_oe_d = (state_d == S_INHIBIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            frame_q    <= '1;
            edge_cnt_q <= '0;
            inh_cnt_q  <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_s3_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            edge_cnt_q <= edge_cnt_d;
            inh_cnt_q  <= inh_cnt_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            done_q     <= done_d;
            error_q    <= error_d;
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_s3_q   <= clk_s2_q;
            dat_s1_q   <= ps2_dat;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign bus.o_busy  = (state_q != S_IDLE);
    assign bus.o_done  = done_q;
    assign bus.o_error = error_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
    localparam int INH = 200;
    localparam int TMO = 3000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wire  ps2_clk;
    wire  ps2_dat;
    logic dev_clk_low;
    logic dev_dat_low;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_host_tx_if bus();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse counters: each cycle a pulse output is high counts once, so a
    // stretched pulse shows up as an extra count.
    int done_cnt = 0;
    int err_cnt = 0;
    int overlap_cnt = 0;
    always @(negedge clk) begin
        if (bus.o_done === 1'b1)  done_cnt <= done_cnt + 1;
        if (bus.o_error === 1'b1) err_cnt  <= err_cnt + 1;
        if ((bus.o_done === 1'b1 || bus.o_error === 1'b1) && bus.o_busy !== 1'b0)
            overlap_cnt <= overlap_cnt + 1;
    end

    // Expected frame as the device sees it, bit 0 first: data, odd parity, stop.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        bus.i_byte = b;
        bus.i_send = 1'b1;
        @(negedge clk);
        bus.i_send = 1'b0;
        chk({tag, "_busy_after_send"}, 32'(bus.o_busy), 32'd1);
        chk({tag, "_clk_low_after_send"}, 32'(ps2_clk), 32'd0);
    endtask

    task automatic measure_inhibit(output int n, output logic dat_at_release);
        n = 0;
        while (ps2_clk === 1'b0 && n < INH * 4) begin
            n++;
            @(negedge clk);
        end
        dat_at_release = ps2_dat;
    endtask

    // Device clock generator. Host data is sampled 3 cycles after each falling
    // edge. Returns early after stop_after edges (0 = run full frame).
    task automatic device_clock(input int h, input bit ack_hi, input int stop_after,
                                input int inject_edge, output logic [9:0] bits);
        bits = '1;
        tick(h);
        for (int e = 1; e <= 11; e++) begin
            if (e == 11) begin
                dev_dat_low = !ack_hi;
                tick(h / 2);
            end
            dev_clk_low = 1'b1;
            tick(3);
            if (e <= 10) bits[e-1] = ps2_dat;
            if (e == inject_edge) begin
                bus.i_byte = 8'h55;
                bus.i_send = 1'b1;
                @(negedge clk);
                bus.i_send = 1'b0;
                tick(h - 4);
            end else begin
                tick(h - 3);
            end
            dev_clk_low = 1'b0;
            tick(h);
            if (e == stop_after) return;
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic do_frame(input logic [7:0] b, input int h, input bit ack_hi,
                            input int inject_edge, input string tag);
        int          d0, e0, n;
        logic        dr;
        logic [9:0]  bits;
        d0 = done_cnt;
        e0 = err_cnt;
        send(b, tag);
        measure_inhibit(n, dr);
        chk({tag, "_inhibit_len"}, 32'(n), 32'(INH));
        chk({tag, "_start_bit"}, 32'(dr), 32'd0);
        device_clock(h, ack_hi, 0, inject_edge, bits);
        tick(20);
        chk({tag, "_frame"}, 32'(bits), 32'(model_frame(b)));
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), ack_hi ? 32'd0 : 32'd1);
        chk({tag, "_err_pulses"}, 32'(err_cnt - e0), ack_hi ? 32'd1 : 32'd0);
        chk({tag, "_busy_after"}, 32'(bus.o_busy), 32'd0);
        chk({tag, "_lines_released"}, {30'd0, ps2_clk, ps2_dat}, 32'd3);
    endtask

    initial begin
        int          n, t, d0, e0;
        logic        dr;
        logic [9:0]  bits;
        logic [7:0]  rb;

        reset       = 1'b1;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        bus.i_byte  = 8'h00;
        bus.i_send  = 1'b0;
        tick(3);
        chk("reset_outputs", {29'd0, bus.o_busy, bus.o_done, bus.o_error}, 32'd0);
        chk("reset_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);

        // Reset and i_send in the same cycle: reset wins.
        bus.i_byte = 8'hF4;
        bus.i_send = 1'b1;
        @(negedge clk);
        bus.i_send = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_beats_send", {30'd0, bus.o_busy, ps2_clk}, 32'd1);

        do_frame(8'hF4, 20, 1'b0, 0, "f4");
        do_frame(8'h00, 16, 1'b0, 0, "x00");
        do_frame(8'hFF, 16, 1'b0, 0, "xff");
        do_frame(8'hA7, 12, 1'b1, 0, "ack_hi");
        do_frame(8'hF4, 18, 1'b0, 4, "send_while_busy");

        for (int i = 0; i < 5; i++) begin
            rb = 8'($urandom_range(0, 255));
            do_frame(rb, int'($urandom_range(8, 20)), 1'b0, 0, $sformatf("rnd%0d", i));
        end

        // Reset mid-frame after the 5th device edge; bit 4 of 0xE0 is 0 so the
        // host is driving ps2_dat low when reset arrives.
        send(8'hE0, "rst");
        measure_inhibit(n, dr);
        device_clock(12, 1'b0, 5, 0, bits);
        chk("rst_dat_driven_before", 32'(ps2_dat), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", {29'd0, bus.o_busy, bus.o_done, bus.o_error}, 32'd0);
        chk("rst_mid_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
        reset = 1'b0;
        tick(2);
        do_frame(8'hF4, 14, 1'b0, 0, "after_rst");

        // Silent device after request-to-send.
        e0 = err_cnt;
        d0 = done_cnt;
        send(8'h3C, "silent");
        measure_inhibit(n, dr);
`ifdef PS2_TX_TIMEOUT_EN
        t = 0;
        while (bus.o_error !== 1'b1 && t < TMO + 50) begin
            @(negedge clk);
            t++;
        end
        chk("timeout_latency", 32'(t), 32'(TMO));
        chk("timeout_busy", 32'(bus.o_busy), 32'd0);
        tick(3);
        chk("timeout_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
        chk("timeout_err_pulses", 32'(err_cnt - e0), 32'd1);
`else
        tick(TMO + 500);
        chk("no_watchdog_busy", 32'(bus.o_busy), 32'd1);
        chk("no_watchdog_err", 32'(err_cnt - e0), 32'd0);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
`endif
        chk("silent_no_done", 32'(done_cnt - d0), 32'd0);
        chk("pulse_busy_overlap", 32'(overlap_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends single command bytes to the PS/2 mouse over the same open-drain PS2_CLK/PS2_DAT pair that the mouse receiver listens on, for example 0xF4 (enable data reporting) or 0xFF (reset). It runs the full host request-to-send sequence, shifts out the frame on device-generated clock edges, and checks the device acknowledge. `o_busy` tells the receiver to ignore line activity while a transmission is in progress.

## Interface
- INHIBIT_CYCLES, 6000: clk cycles the host holds PS2_CLK low before request-to-send (120 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: watchdog limit from request-to-send to acknowledge (15 ms at 50 MHz).
- clk  input  1  system clock, CLOCK_50.
- reset  input  1  reset, synchronous, active-high.
- i_byte  input  8  command byte; sampled in the cycle `i_send` is accepted.
- i_send  input  1  start request; accepted only in IDLE.
- o_busy  output  1  high from the cycle after acceptance until the cycle of the done or error pulse.
- o_done  output  1  one-cycle pulse; device acknowledged and both lines have returned high.
- o_error  output  1  one-cycle pulse; missing ACK (data high) or timeout.
- ps2_clk  inout  1  open-drain; only ever driven 0 or z.
- ps2_dat  inout  1  open-drain; only ever driven 0 or z.

## Operation
- Inputs: ps2_clk and ps2_dat each pass through a 2-FF synchronizer. A falling edge is synchronized clock previous=1, current=0.
- Frame: shift register holds {1 (stop), odd parity, i_byte}, sent LSB first. Parity = ~^i_byte.
- IDLE: both lines released. On `i_send`, latch the frame and go to INHIBIT.
- INHIBIT: drive ps2_clk low for exactly INHIBIT_CYCLES cycles, then go to RTS.
- RTS: drive ps2_dat low (start bit) and release ps2_clk. Stay until the synchronized clock reads 1, so the host's own release is never counted as a device edge. Then go to DATA with edge count 0.
- DATA: on each device falling edge, increment the count.
  - Edges 1–9: drive ps2_dat from the next frame bit (data bits 0–7, then parity). A 1 means release, a 0 means drive low.
  - Edge 10: release ps2_dat (stop bit), then go to ACK.
- ACK: on the next falling edge, sample synchronized data.
  - 0: go to WAIT_IDLE.
  - 1: pulse `o_error` and go to IDLE.
- WAIT_IDLE: wait until both synchronized lines read 1, then pulse `o_done` and go to IDLE.
- `i_send` while busy: ignored; the latched frame is unchanged.
- Reset, including mid-frame: state IDLE, both lines released, all outputs 0, counters cleared. When reset and `i_send` are high in the same cycle, reset wins.

## Timing
- Reset values: o_busy=0, o_done=0, o_error=0, ps2_clk=z, ps2_dat=z.
- ps2_clk goes low in the cycle after `i_send` is accepted, together with o_busy=1.
- ps2_dat changes within 3 clk cycles of the device falling edge. The device low phase is at least 30 us, so this is well inside the window.
- `o_done` or `o_error` is asserted for exactly 1 cycle. `o_busy` drops in that same cycle.
- A new `i_send` is accepted in the cycle after a done or error pulse.
- Counters: the inhibit counter is ceil(log2(INHIBIT_CYCLES+1)) bits wide and the timeout counter is ceil(log2(TIMEOUT_CYCLES+1)) bits wide. The edge counter is 4 bits. No counter wraps.

## Configuration
- PS2_TX_TIMEOUT_EN defined:
  - A watchdog starts on entry to RTS.
  - If TIMEOUT_CYCLES elapse before the ACK sample, both lines are released, `o_error` pulses and the block returns to IDLE.
  - The watchdog also applies in WAIT_IDLE.
- PS2_TX_TIMEOUT_EN undefined:
  - No watchdog; the block waits indefinitely for device edges.
  - `o_error` is raised only by ACK=1.

## Test plan
- Send 0xF4 with the device model clocking at 12 kHz and giving ACK=0. Required: data bits 0,0,1,0,1,1,1,1; parity 0; stop released; `o_done` pulses once; `o_busy` low afterwards.
- Send 0x00, then 0xFF. Required: parity bit 1 in both frames; ps2_clk held low exactly 6000 cycles before data goes low.
- Device returns ACK=1. Required: `o_error` pulses once, `o_done` never asserts, lines released.
- With PS2_TX_TIMEOUT_EN defined and the device silent after RTS. Required: `o_error` exactly 750000 cycles after RTS entry, then IDLE. Without the macro: `o_busy` stays 1.
- Reset asserted after the 5th device edge. Required: next cycle both lines z and all outputs 0. A following send of 0xF4 completes normally.
- `i_send` pulsed with 0x55 while busy sending 0xF4. Required: 0xF4 frame unaltered, one `o_done` only.
